button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 15 +
 rtl/button_conditioner_channel.sv | 96 +++++++++
 rtl/button_conditioner.sv | 30 +++
 tb/tb_button_conditioner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM encoding
// and the default debounce length.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 10 ms at the 5 MHz base clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/button_conditioner_channel.sv
// One debounced button channel: two-flop synchronizer, four-state debounce
// FSM with a saturating stability counter, and registered level/pulse outputs.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    sync_q;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          s;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Level is registered from the next state so it changes with the pulse.
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces WIDTH independent raw button inputs (bit 0 = submit, bit 1 =
// advance) into clean levels plus one-cycle press/release pulses.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_channel (
            .clk      (clk),
            .rst_ni   (reset),
            .btn_i    (btn_in[g]),
            .level_o  (btn_level[g]),
            .press_o  (btn_press[g]),
            .release_o(btn_release[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (WIDTH=2, DEBOUNCE_CYCLES=4):
// directed latency/bounce/glitch/reset scenarios plus randomized bouncing.
`timescale 1ns/1ps
module tb_button_conditioner;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = N + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_in = 2'b00;
    logic [1:0] btn_level, btn_press, btn_release;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #100 clk = ~clk;

    button_conditioner #(
        .WIDTH(2),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // Reference: a change is accepted once the synchronized input (btn_in two
    // samples late) has disagreed with the current level N+1 samples in a row.
    logic [1:0]  dly1, dly2, m_level, m_press, m_release;
    int unsigned run [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly1 <= '0; dly2 <= '0; m_level <= '0; m_press <= '0; m_release <= '0;
            run[0] <= 0; run[1] <= 0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                m_press[ch]   <= 1'b0;
                m_release[ch] <= 1'b0;
                if (dly2[ch] == m_level[ch]) begin
                    run[ch] <= 0;
                end else if (run[ch] + 1 == N + 1) begin
                    m_level[ch] <= dly2[ch];
                    run[ch]     <= 0;
                    if (dly2[ch]) m_press[ch] <= 1'b1;
                    else          m_release[ch] <= 1'b1;
                end else begin
                    run[ch] <= run[ch] + 1;
                end
            end
            dly2 <= dly1;
            dly1 <= btn_in;
        end
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = 2'b00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({btn_level, btn_press, btn_release} !== 6'b0) begin
            $display("FAIL reset_state: got lvl=%b prs=%b rel=%b, expected all 0",
                     btn_level, btn_press, btn_release);
        end else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int unsigned lat = 0, np0 = 0, quiet1 = 0;
        btn_in = 2'b01;
        for (int unsigned c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (btn_press[0] === 1'b1) begin
                np0++;
                if (lat == 0) lat = c;
            end
            if (btn_press[1] !== 1'b0 || btn_level[1] !== 1'b0 || btn_release[1] !== 1'b0) quiet1++;
        end
        n_checks++;
        if (lat != LAT) $display("FAIL press_latency: got %0d, expected %0d", lat, LAT);
        else n_pass++;
        n_checks++;
        if (np0 != 1) $display("FAIL press_count: got %0d, expected 1", np0);
        else n_pass++;
        n_checks++;
        if (btn_level[0] !== 1'b1) $display("FAIL press_level: got %b, expected 1", btn_level[0]);
        else n_pass++;
        n_checks++;
        if (quiet1 != 0) $display("FAIL press_ch1_quiet: got %0d active cycles, expected 0", quiet1);
        else n_pass++;
    endtask

    task automatic test_release();
        int unsigned lat = 0, nrel = 0, nprs = 0;
        btn_in[0] = 1'b0;
        for (int unsigned c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (btn_release[0] === 1'b1) begin
                nrel++;
                if (lat == 0) lat = c;
            end
            if (btn_press[0] === 1'b1) nprs++;
        end
        n_checks++;
        if (lat != LAT || nrel != 1)
            $display("FAIL release_latency: got lat=%0d n=%0d, expected lat=%0d n=1", lat, nrel, LAT);
        else n_pass++;
        n_checks++;
        if (btn_level[0] !== 1'b0 || nprs != 0)
            $display("FAIL release_level: got lvl=%b presses=%0d, expected lvl=0 presses=0", btn_level[0], nprs);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic [3:0]  pat = 4'b0101;
        int unsigned lat = 0, npre = 0, np = 0;
        for (int i = 0; i < 4; i++) begin
            btn_in[0] = pat[i];
            @(negedge clk);
            if (btn_press[0] === 1'b1) npre++;
        end
        btn_in[0] = 1'b1;
        for (int unsigned c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (btn_press[0] === 1'b1) begin
                np++;
                if (lat == 0) lat = c;
            end
        end
        n_checks++;
        if (npre != 0 || np != 1)
            $display("FAIL bounce_count: got pre=%0d post=%0d, expected pre=0 post=1", npre, np);
        else n_pass++;
        n_checks++;
        if (lat != LAT) $display("FAIL bounce_latency: got %0d, expected %0d", lat, LAT);
        else n_pass++;
        btn_in[0] = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_glitch();
        int unsigned bad = 0;
        btn_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        btn_in[1] = 1'b0;
        for (int unsigned c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (btn_press[1] !== 1'b0 || btn_level[1] !== 1'b0 || btn_release[1] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL glitch_filtered: got %0d active cycles, expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int unsigned lat = 0, split = 0;
        btn_in = 2'b11;
        for (int unsigned c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (btn_press == 2'b11 && lat == 0) lat = c;
            if (btn_press == 2'b01 || btn_press == 2'b10) split++;
        end
        n_checks++;
        if (lat != LAT || split != 0)
            $display("FAIL simultaneous_press: got lat=%0d split=%0d, expected lat=%0d split=0", lat, split, LAT);
        else n_pass++;
        btn_in = 2'b00;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset_midcount();
        int unsigned lat0 = 0, lat1 = 0;
        btn_in = 2'b10;
        repeat (12) @(negedge clk);
        btn_in = 2'b11;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({btn_level, btn_press, btn_release} !== 6'b0)
            $display("FAIL reset_immediate: got lvl=%b prs=%b rel=%b, expected all 0",
                     btn_level, btn_press, btn_release);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (btn_press[0] === 1'b1 && lat0 == 0) lat0 = c;
            if (btn_press[1] === 1'b1 && lat1 == 0) lat1 = c;
        end
        n_checks++;
        if (lat0 != LAT || lat1 != LAT)
            $display("FAIL reset_fresh_press: got lat0=%0d lat1=%0d, expected %0d", lat0, lat1, LAT);
        else n_pass++;
    endtask

    task automatic test_random();
        int unsigned hold [2];
        int unsigned bad = 0, overlap = 0;
        hold[0] = 1; hold[1] = 1;
        for (int unsigned c = 0; c < 600; c++) begin
            @(negedge clk);
            n_checks++;
            if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_release) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random_model cyc %0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                             c, btn_level, btn_press, btn_release, m_level, m_press, m_release);
            end else n_pass++;
            if ((btn_press & btn_release) != 2'b00) overlap++;
            for (int ch = 0; ch < 2; ch++) begin
                hold[ch]--;
                if (hold[ch] == 0) begin
                    btn_in[ch] = ~btn_in[ch];
                    hold[ch]   = $urandom_range(1, 9);
                end
            end
        end
        n_checks++;
        if (overlap != 0) $display("FAIL random_press_release_overlap: got %0d, expected 0", overlap);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
